// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes, FSM states
// and the datapath mux encodings driven by the controller.
package riscv_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal,
    StLui,
    StTrap
  } state_e;

  // ResultSrc
  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_DATA       = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;
  localparam logic [1:0] RES_IMM_EXT    = 2'b11;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RD1    = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The controller is the master: it consumes the
// instruction/ALU/memory status and drives every datapath control.
interface multicycle_controller_if #(
  parameter int unsigned RET_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [2:0]       ImmSrc;
  logic             illegal;
  logic [RET_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
           ImmSrc, illegal, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
           ImmSrc, illegal, instret
  );
endinterface

// File: rtl/instr_decoder.sv
// Opcode decoder: immediate format select and the state DECODE moves to.
// Unsupported (or disabled) opcodes resolve to the trap state.
module instr_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1,
  parameter bit ENABLE_LUI = 1'b1
) (
  input  logic [6:0] opcode,
  output logic [2:0] immSrc,
  output state_e     decodeNext
);

  // Immediate format is reported for every opcode regardless of legality
  always_comb begin
    immSrc     = IMM_I;
    decodeNext = StTrap;
    case (opcode)
      OP_LW:  decodeNext = StMemAdr;
      OP_SW: begin
        immSrc     = IMM_S;
        decodeNext = StMemAdr;
      end
      OP_R:   decodeNext = StExecuteR;
      OP_I:   decodeNext = StExecuteI;
      OP_BEQ: begin
        immSrc     = IMM_B;
        decodeNext = StBeq;
      end
      OP_JAL: begin
        immSrc     = IMM_J;
        decodeNext = ENABLE_JAL ? StJal : StTrap;
      end
      OP_LUI: begin
        immSrc     = IMM_U;
        decodeNext = ENABLE_LUI ? StLui : StTrap;
      end
      default: decodeNext = StTrap;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB, drives the
// shared-memory datapath, stalls on mem_ready, traps illegal opcodes and counts
// retired instructions.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ENABLE_JAL    = 1'b1,
  parameter bit          ENABLE_LUI    = 1'b1,
  parameter int unsigned RET_W         = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  state_e           stateQ;
  state_e           stateD;
  state_e           decodeNext;
  logic [RET_W-1:0] instretQ;
  logic             illegalQ;
  logic             ready;
  logic [2:0]       immSrc;

  logic             adrSrc;
  logic             memWrite;
  logic             irWrite;
  logic             regWrite;
  logic             pcUpdate;
  logic             branch;
  logic [1:0]       resultSrc;
  logic [1:0]       aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       aluOp;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  instr_decoder #(
    .ENABLE_JAL (ENABLE_JAL),
    .ENABLE_LUI (ENABLE_LUI)
  ) u_decoder (
    .opcode     (bus.opcode),
    .immSrc     (immSrc),
    .decodeNext (decodeNext)
  );

  // Next-state: wait states hold until ready; TRAP only leaves through reset
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StFetch:    if (ready) stateD = StDecode;
      StDecode:   stateD = decodeNext;
      StMemAdr:   stateD = (bus.opcode == OP_SW) ? StMemWrite : StMemRead;
      StMemRead:  if (ready) stateD = StMemWb;
      StMemWb:    stateD = StFetch;
      StMemWrite: if (ready) stateD = StFetch;
      StExecuteR: stateD = StAluWb;
      StExecuteI: stateD = StAluWb;
      StAluWb:    stateD = StFetch;
      StBeq:      stateD = StFetch;
      StJal:      stateD = StAluWb;
      StLui:      stateD = StFetch;
      StTrap:     stateD = StTrap;
      default:    stateD = StFetch;
    endcase
  end

  // State, retire counter (bumped on every return to FETCH) and sticky illegal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StFetch;
      instretQ <= '0;
      illegalQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (stateQ != StFetch && stateD == StFetch) begin
        instretQ <= instretQ + RET_W'(1);
      end
      if (stateQ == StDecode && stateD == StTrap) begin
        illegalQ <= 1'b1;
      end
    end
  end

  // Moore decode of datapath controls; only FETCH strobes look at ready
  always_comb begin
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    resultSrc = RES_ALU_OUT;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RD2;
    aluOp     = ALUOP_ADD;
    unique case (stateQ)
      StFetch: begin
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU_RESULT;
        irWrite   = ready;
        pcUpdate  = ready;
      end
      StDecode: begin
        aluSrcA = SRCA_OLD_PC;
        aluSrcB = SRCB_IMM;
      end
      StMemAdr: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
      end
      StMemRead: adrSrc = 1'b1;
      StMemWb: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
      end
      StMemWrite: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      StExecuteR: begin
        aluSrcA = SRCA_RD1;
        aluOp   = ALUOP_FUNCT;
      end
      StExecuteI: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
      end
      StAluWb: regWrite = 1'b1;
      StBeq: begin
        aluSrcA = SRCA_RD1;
        aluOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      StJal: begin
        aluSrcA  = SRCA_OLD_PC;
        aluSrcB  = SRCB_FOUR;
        pcUpdate = 1'b1;
      end
      StLui: begin
        resultSrc = RES_IMM_EXT;
        regWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held, even though state already reads FETCH
  assign bus.PCWrite   = ~reset & (pcUpdate | (branch & bus.zero));
  assign bus.IRWrite   = ~reset & irWrite;
  assign bus.MemWrite  = ~reset & memWrite;
  assign bus.RegWrite  = ~reset & regWrite;
  assign bus.AdrSrc    = adrSrc;
  assign bus.ResultSrc = resultSrc;
  assign bus.ALUSrcA   = aluSrcA;
  assign bus.ALUSrcB   = aluSrcB;
  assign bus.ALUOp     = aluOp;
  assign bus.ImmSrc    = immSrc;
  assign bus.illegal   = illegalQ;
  assign bus.instret   = instretQ;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Two instances: A (handshake on, jal/lui on,
// 4-bit retire counter) and B (handshake off, jal disabled, 32-bit counter).
// Expected behaviour comes from a per-opcode table of control steps.
module tb_multicycle_controller;

  typedef struct packed {
    logic       memWait;  // step holds while mem_ready is low
    logic       fetch;    // IRWrite/PCWrite only when ready
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] op;
  } step_t;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] LUI   = 7'b0110111;

  logic       clk      = 1'b0;
  logic       rstA     = 1'b1;
  logic       rstB     = 1'b1;
  logic [6:0] opcode   = 7'b0000011;
  logic       zero     = 1'b0;
  logic       memReady = 1'b1;

  int    errors = 0;
  int    checks = 0;
  int    cntA   = 0;
  int    cntB   = 0;
  bit    illA   = 1'b0;
  bit    illB   = 1'b0;
  step_t steps[$];

  always #5 clk = ~clk;

  multicycle_controller_if #(.RET_W(4))  busA ();
  multicycle_controller_if #(.RET_W(32)) busB ();

  assign busA.opcode    = opcode;
  assign busA.zero      = zero;
  assign busA.mem_ready = memReady;
  assign busB.opcode    = opcode;
  assign busB.zero      = zero;
  assign busB.mem_ready = memReady;

  multicycle_controller #(
    .MEM_HANDSHAKE (1'b1),
    .ENABLE_JAL    (1'b1),
    .ENABLE_LUI    (1'b1),
    .RET_W         (4)
  ) dutA (
    .clk   (clk),
    .reset (rstA),
    .bus   (busA.master)
  );

  multicycle_controller #(
    .MEM_HANDSHAKE (1'b0),
    .ENABLE_JAL    (1'b0),
    .ENABLE_LUI    (1'b1),
    .RET_W         (32)
  ) dutB (
    .clk   (clk),
    .reset (rstB),
    .bus   (busB.master)
  );

  function automatic step_t mk(input logic w, input logic f, input logic pcw, input logic adr,
                               input logic mw, input logic irw, input logic rw,
                               input logic [1:0] res, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [1:0] op);
    step_t s;
    s.memWait = w;
    s.fetch   = f;
    s.pcw     = pcw;
    s.adr     = adr;
    s.mw      = mw;
    s.irw     = irw;
    s.rw      = rw;
    s.res     = res;
    s.sa      = sa;
    s.sb      = sb;
    s.op      = op;
    return s;
  endfunction

  function automatic step_t fetchStep();
    return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00);
  endfunction

  function automatic logic [2:0] immOf(input logic [6:0] op);
    case (op)
      SW:      return 3'b001;
      BEQ:     return 3'b010;
      JAL:     return 3'b011;
      LUI:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [15:0] expOf(input step_t s, input logic rdy, input logic [6:0] op);
    logic pcw;
    logic irw;
    pcw = s.fetch ? (s.pcw & rdy) : s.pcw;
    irw = s.fetch ? (s.irw & rdy) : s.irw;
    return {pcw, s.adr, s.mw, irw, s.rw, s.res, s.sa, s.sb, s.op, immOf(op)};
  endfunction

  function automatic logic [15:0] outsOf(input bit useB);
    if (useB) begin
      return {busB.PCWrite, busB.AdrSrc, busB.MemWrite, busB.IRWrite, busB.RegWrite,
              busB.ResultSrc, busB.ALUSrcA, busB.ALUSrcB, busB.ALUOp, busB.ImmSrc};
    end
    return {busA.PCWrite, busA.AdrSrc, busA.MemWrite, busA.IRWrite, busA.RegWrite,
            busA.ResultSrc, busA.ALUSrcA, busA.ALUSrcB, busA.ALUOp, busA.ImmSrc};
  endfunction

  // Control sequence of one instruction when ready is always high
  task automatic buildSteps(input logic [6:0] op, input logic z, input bit jalOk,
                            output bit trap);
    step_t memAdr;
    step_t aluWb;
    memAdr = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00);
    aluWb  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    steps.delete();
    trap = 1'b0;
    steps.push_back(fetchStep());
    steps.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00));
    if (op == LW) begin
      steps.push_back(memAdr);
      steps.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
      steps.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00));
    end else if (op == SW) begin
      steps.push_back(memAdr);
      steps.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
    end else if (op == RTYPE) begin
      steps.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10));
      steps.push_back(aluWb);
    end else if (op == ITYPE) begin
      steps.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10));
      steps.push_back(aluWb);
    end else if (op == BEQ) begin
      steps.push_back(mk(1'b0, 1'b0, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01));
    end else if (op == JAL && jalOk) begin
      steps.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00));
      steps.push_back(aluWb);
    end else if (op == LUI) begin
      steps.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00));
    end else begin
      trap = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycleCheck(input bit useB, input string tag, input logic [15:0] expOuts);
    logic [31:0] ret;
    logic        ill;
    ret = useB ? busB.instret : {28'b0, busA.instret};
    ill = useB ? busB.illegal : busA.illegal;
    check({tag, " outs"}, {16'b0, outsOf(useB)}, {16'b0, expOuts});
    check({tag, " instret"}, ret, useB ? 32'(cntB) : 32'(cntA % 16));
    check({tag, " illegal"}, {31'b0, ill}, {31'b0, useB ? illB : illA});
  endtask

  // Assert reset mid-cycle, check the idle FETCH view, release just after a rising edge
  task automatic resetNow(input bit useB);
    if (useB) begin
      rstB = 1'b1;
      cntB = 0;
      illB = 1'b0;
    end else begin
      rstA = 1'b1;
      cntA = 0;
      illA = 1'b0;
    end
    memReady = 1'b1;
    #1;
    cycleCheck(useB, "reset", expOf(fetchStep(), 1'b0, opcode));
    @(posedge clk);
    #1;
    if (useB) rstB = 1'b0;
    else rstA = 1'b0;
  endtask

  task automatic runInstr(input bit useB, input logic [6:0] op, input logic z,
                          input int fetchLows, input int memLows, input bit abortInWrite,
                          output bit trapped);
    bit   trap;
    int   lows;
    logic rdy;
    buildSteps(op, z, !useB, trap);
    trapped = trap;
    foreach (steps[i]) begin
      lows = 0;
      if (steps[i].memWait && !useB) lows = steps[i].fetch ? fetchLows : memLows;
      for (int k = 0; k <= lows; k++) begin
        @(negedge clk);
        opcode = op;
        zero   = (op == BEQ) ? z : 1'($urandom_range(0, 1));
        if (steps[i].memWait && !useB) memReady = (k == lows);
        else memReady = 1'($urandom_range(0, 1));
        rdy = useB ? 1'b1 : memReady;
        #1;
        cycleCheck(useB, $sformatf("op=%b step%0d", op, i), expOf(steps[i], rdy, op));
        if (abortInWrite && steps[i].memWait && !steps[i].fetch && !useB) begin
          resetNow(useB);
          return;
        end
      end
    end
    if (trap) begin
      if (useB) illB = 1'b1;
      else illA = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        memReady = 1'($urandom_range(0, 1));
        zero     = 1'($urandom_range(0, 1));
        #1;
        cycleCheck(useB, $sformatf("trap op=%b", op), {13'b0, immOf(op)});
      end
    end else if (useB) begin
      cntB++;
    end else begin
      cntA++;
    end
  endtask

  initial begin
    bit         tr;
    logic [6:0] op;
    logic [6:0] opList [7];
    opList = '{LW, SW, RTYPE, ITYPE, BEQ, JAL, LUI};

    @(negedge clk);
    #1;
    cycleCheck(1'b1, "por B", expOf(fetchStep(), 1'b0, opcode));
    resetNow(1'b0);

    // Reset while MemWrite is being held with mem_ready low
    runInstr(1'b0, SW, 1'b0, 0, 3, 1'b1, tr);
    runInstr(1'b0, LW, 1'b0, 0, 0, 1'b0, tr);
    runInstr(1'b0, SW, 1'b0, 0, 3, 1'b0, tr);
    runInstr(1'b0, BEQ, 1'b1, 0, 0, 1'b0, tr);
    runInstr(1'b0, BEQ, 1'b0, 0, 0, 1'b0, tr);
    runInstr(1'b0, JAL, 1'b0, 1, 0, 1'b0, tr);
    runInstr(1'b0, RTYPE, 1'b0, 2, 0, 1'b0, tr);
    runInstr(1'b0, ITYPE, 1'b0, 0, 0, 1'b0, tr);
    runInstr(1'b0, LW, 1'b0, 1, 2, 1'b0, tr);

    // 17 lui on a 4-bit counter wraps to 1
    @(negedge clk);
    resetNow(1'b0);
    for (int n = 0; n < 17; n++) runInstr(1'b0, LUI, 1'b0, 0, 0, 1'b0, tr);
    @(negedge clk);
    memReady = 1'b0;
    #1;
    check("lui wrap", {28'b0, busA.instret}, 32'd1);

    // Random instruction stream on A; illegal opcodes trap and get reset
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 7) == 7) ? 7'($urandom) : opList[$urandom_range(0, 6)];
      runInstr(1'b0, op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
               1'b0, tr);
      if (tr) resetNow(1'b0);
    end
    rstA = 1'b1;

    // B: jal disabled traps, sticky until reset; handshake ignored
    @(negedge clk);
    resetNow(1'b1);
    runInstr(1'b1, LUI, 1'b0, 0, 0, 1'b0, tr);
    runInstr(1'b1, JAL, 1'b0, 0, 0, 1'b0, tr);
    check("jal disabled traps", {31'b0, tr}, 32'd1);
    resetNow(1'b1);
    for (int n = 0; n < 30; n++) begin
      op = ($urandom_range(0, 7) == 7) ? 7'($urandom) : opList[$urandom_range(0, 6)];
      runInstr(1'b1, op, 1'($urandom_range(0, 1)), 0, 0, 1'b0, tr);
      if (tr) resetNow(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle control unit for the RISC-V core; successor to the single-cycle combinational main decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives datapath muxes and enables, stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.
- Sits between the instruction register (opcode, funct fields stay in the ALU decoder) and the shared-memory datapath.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored (treated as 1)
ENABLE_JAL, 1, 1 = jal (1101111) supported; 0 = jal decodes as illegal
ENABLE_LUI, 1, 1 = lui (0110111) supported; 0 = lui decodes as illegal
RET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  PC enable = PCUpdate | (Branch & zero)
AdrSrc  out  1  0 = PC, 1 = ALUOut
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction register / OldPC enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ALUOp  out  2  00 add, 01 sub/branch, 10 funct-decoded
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from opcode, all states)
illegal  out  1  sticky: unsupported opcode reached DECODE
instret  out  RET_W  retired-instruction count

Behaviour:
- Moore FSM, one state register; outputs are decoded from state, except PCWrite (uses zero) and handshake-gated strobes. Unlisted outputs are 0 in every state.
- Reset (async, any state, mid-access included): state = FETCH, instret = 0, illegal = 0. While reset is asserted all strobes (PCWrite, IRWrite, MemWrite, RegWrite) are 0; mux selects take their FETCH values.
- "ready" means mem_ready when MEM_HANDSHAKE = 1, otherwise 1.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when ready. Go to DECODE if ready, else stay.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other -> TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE (opcode held stable by IR).
  - MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB when ready, else stay.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until ready -> FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - LUI: ResultSrc=11, RegWrite=1 -> FETCH.
  - TRAP: all strobes 0, illegal=1. Stays in TRAP until reset.
- illegal is set on the DECODE->TRAP transition; only reset clears it.
- instret increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^RET_W and does not increment when entering TRAP.
- Latency with ready always 1:
  - lw 5 cycles
  - sw 4
  - R/I-ALU 4
  - beq 3
  - jal 4
  - lui 3
- Each mem_ready-low cycle in a wait state adds 1 cycle.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI)
  - state enum
  - ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encoding constants
- One sub-module is natural: instr_decoder (combinational ImmSrc from opcode, plus the legal-opcode check honouring ENABLE_JAL/ENABLE_LUI). The FSM and instret counter stay in the top.

Test Plan:
- Reset mid-MEMWRITE with mem_ready=0 -> MemWrite drops to 0 immediately; state FETCH, instret=0, illegal=0.
- lw (0000011), mem_ready=1 -> state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5; ResultSrc=01; instret 0->1.
- sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite high 4 consecutive cycles, then FETCH; total 7 cycles; RegWrite never 1.
- beq with zero=1 vs zero=0 -> PCWrite=1 in BEQ cycle only when zero=1; both retire in 3 cycles.
- jal with ENABLE_JAL=1 -> JAL cycle PCWrite=1, then ALUWB RegWrite=1. With ENABLE_JAL=0 -> TRAP, illegal=1 sticky, instret unchanged, no strobes until reset.
- instret with RET_W=4 and 17 back-to-back lui instructions -> wraps to 1; each lui takes 3 cycles with ResultSrc=11.
